// File: rtl/ristretto_mem_arb_pkg.sv
// Shared types for the fetch/LSU memory arbiter: requester ownership,
// arbiter FSM states and the arbitration priority rule.
package ristretto_mem_arb_pkg;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_GNT    = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } arb_state_e;

    // LSU has priority on a conflict unless fetch has been starved long enough.
    function automatic owner_e arb_pick(input logic if_req,
                                        input logic lsu_req,
                                        input logic starved);
        if (if_req && (!lsu_req || starved)) begin
            return OWN_IF;
        end
        return OWN_LSU;
    endfunction

endpackage

// File: rtl/ristretto_pkg.sv
// Core-level package; re-exports the memory arbiter types so core files can
// reach them through a single import.
package ristretto_pkg;

    import ristretto_mem_arb_pkg::*;
    export ristretto_mem_arb_pkg::*;

endpackage

// File: rtl/ristretto_mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one shared
// memory port, one transaction outstanding at a time, with anti-starvation
// for fetch and flush-based squashing of fetch responses.
module ristretto_mem_arbiter
    import ristretto_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                if_flush_i,

    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                busy_o
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e      state;
    owner_e          owner;
    logic [SW-1:0]   starve_cnt;
    logic            kill;

    logic            any_req;
    logic            conflict;
    logic            starved;
    owner_e          winner;
    owner_e          sel;
    logic            req_phase;
    logic            rsp_fire;

    // Arbitration decision and request/response phase qualifiers.
    always_comb begin
        any_req   = if_req_i | lsu_req_i;
        conflict  = if_req_i & lsu_req_i;
        starved   = (starve_cnt == SW'(STARVE_MAX));
        winner    = arb_pick(if_req_i, lsu_req_i, starved);
        sel       = (state == ST_IDLE) ? winner : owner;
        req_phase = !rst_i && (((state == ST_IDLE) && any_req) || (state == ST_WAIT_GNT));
        rsp_fire  = !rst_i && (state == ST_WAIT_RVALID) && mem_rvalid_i;
    end

    // Forward the selected requester onto the memory port and route grants/responses back.
    always_comb begin
        mem_req_o    = req_phase;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        if (req_phase) begin
            if (sel == OWN_IF) begin
                mem_be_o   = '1;
                mem_addr_o = if_addr_i;
            end else begin
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end
        end
        if_gnt_o     = req_phase && (sel == OWN_IF) && mem_gnt_i;
        lsu_gnt_o    = req_phase && (sel == OWN_LSU) && mem_gnt_i;
        // A flush on the response cycle itself squashes it as well as an earlier one.
        if_rvalid_o  = rsp_fire && (owner == OWN_IF) && !kill && !if_flush_i;
        lsu_rvalid_o = rsp_fire && (owner == OWN_LSU);
        if_rdata_o   = if_rvalid_o  ? mem_rdata_i : '0;
        lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
        busy_o       = (state != ST_IDLE);
    end

    // Transaction FSM with owner latch, starvation counter and fetch kill flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            owner      <= OWN_LSU;
            starve_cnt <= '0;
            kill       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (any_req) begin
                        owner <= winner;
                        if (winner == OWN_IF) begin
                            starve_cnt <= '0;
                        end else if (conflict && !starved) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                        state <= mem_gnt_i ? ST_WAIT_RVALID : ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if ((owner == OWN_IF) && if_flush_i) begin
                        kill <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        state <= ST_WAIT_RVALID;
                    end
                end
                ST_WAIT_RVALID: begin
                    if (mem_rvalid_i) begin
                        state <= ST_IDLE;
                        kill  <= 1'b0;
                    end else if ((owner == OWN_IF) && if_flush_i) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ristretto_mem_arbiter.sv
// Directed bench for ristretto_mem_arbiter: response scoreboard plus
// immediate-assertion checks on grants and forwarded request fields.
module tb_ristretto_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                if_req = 1'b0;
    logic [ADDR_W-1:0]   if_addr = '0;
    logic                if_gnt, if_rvalid;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_flush = 1'b0;
    logic                lsu_req = 1'b0;
    logic                lsu_we = 1'b0;
    logic [DATA_W/8-1:0] lsu_be = '0;
    logic [ADDR_W-1:0]   lsu_addr = '0;
    logic [DATA_W-1:0]   lsu_wdata = '0;
    logic                lsu_gnt, lsu_rvalid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                mem_req, mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_gnt = 1'b0;
    logic                mem_rvalid = 1'b0;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                busy;

    typedef struct packed {
        logic              is_if;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    n_cmp = 0;
    int    n_err = 0;

    ristretto_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_flush_i(if_flush),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
                 mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy};
    endfunction

    // Response monitor: every forwarded rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (if_rvalid || lsu_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rvalid_port", {62'd0, if_rvalid, lsu_rvalid}, mon_e.is_if ? 64'd2 : 64'd1);
                chk("rdata", mon_e.is_if ? 64'(if_rdata) : 64'(lsu_rdata), 64'(mon_e.data));
                chk("other_rdata_zero", mon_e.is_if ? 64'(lsu_rdata) : 64'(if_rdata), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with live requests: all outputs must stay 0.
        if_req = 1'b1; lsu_req = 1'b1; mem_gnt = 1'b1; if_addr = 32'h11; lsu_addr = 32'h22;
        #3;
        chk("reset_outputs_zero", 64'(any_out()), 64'd0);
        if_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("idle_after_reset", 64'(any_out()), 64'd0);

        // Conflict: LSU wins, then fetch wins after the response.
        tick();
        if_req = 1'b1; if_addr = 32'hA000_0010;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'hB000_0020;
        mem_gnt = 1'b1;
        #1;
        chk("conflict_addr_lsu", 64'(mem_addr), 64'hB000_0020);
        chk("conflict_lsu_gnt", 64'(lsu_gnt), 64'd1);
        chk("conflict_if_gnt", 64'(if_gnt), 64'd0);
        tick();
        lsu_req = 1'b0; lsu_we = 1'b1; lsu_be = 4'h0; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        exp_q.push_back('{is_if: 1'b0, data: 32'h1234_5678});
        #1;
        chk("rvalid_phase_no_req", 64'(mem_req), 64'd0);
        chk("rvalid_phase_busy", 64'(busy), 64'd1);
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        #1;
        chk("fetch_after_addr", 64'(mem_addr), 64'hA000_0010);
        chk("fetch_after_gnt", 64'(if_gnt), 64'd1);
        chk("fetch_we_zero", 64'(mem_we), 64'd0);
        chk("fetch_be_ones", 64'(mem_be), 64'hF);
        tick();
        if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        exp_q.push_back('{is_if: 1'b1, data: 32'hCAFE_0001});
        tick();
        mem_rvalid = 1'b0;

        // Continuous conflicts: fetch wins the 5th arbitration, LSU the 6th.
        lsu_we = 1'b0; lsu_be = 4'hF;
        if_req = 1'b1; lsu_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if_addr = 32'h1000 + 32'(k); lsu_addr = 32'h2000 + 32'(k);
            mem_gnt = 1'b1;
            #1;
            chk("starve_winner_addr", 64'(mem_addr), (k == 4) ? 64'h1000 + 64'(k) : 64'h2000 + 64'(k));
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5000 + 32'(k);
            exp_q.push_back('{is_if: (k == 4), data: 32'h5000 + 32'(k)});
            tick();
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0; lsu_req = 1'b0;
        tick();

        // Fetch stalled in WAIT_GNT while the LSU requests; stray rvalid ignored.
        if_req = 1'b1; if_addr = 32'hA3A3_0000; mem_gnt = 1'b0;
        #1;
        chk("stall_first_addr", 64'(mem_addr), 64'hA3A3_0000);
        tick();
        lsu_req = 1'b1; lsu_addr = 32'hC3C3_0000;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = (i == 1); mem_rdata = 32'hBAD0_0000;
            #1;
            chk("stall_mem_req", 64'(mem_req), 64'd1);
            chk("stall_addr", 64'(mem_addr), 64'hA3A3_0000);
            chk("stall_lsu_gnt", 64'(lsu_gnt), 64'd0);
            tick();
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        #1;
        chk("stall_release_if_gnt", 64'(if_gnt), 64'd1);
        chk("stall_release_lsu_gnt", 64'(lsu_gnt), 64'd0);

        // Flush while fetch waits for its response: rvalid squashed.
        tick();
        mem_gnt = 1'b0; if_req = 1'b0; lsu_req = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("flush_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("flush_if_rdata", 64'(if_rdata), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("flush_idle_busy", 64'(busy), 64'd0);

        // Flush has no effect on an LSU load.
        tick();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0000_0404; mem_gnt = 1'b1; if_flush = 1'b1;
        tick();
        lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        exp_q.push_back('{is_if: 1'b0, data: 32'h0F0F_0F0F});
        #1;
        chk("flush_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
        tick();
        mem_rvalid = 1'b0; if_flush = 1'b0;
        tick();

        // Store granted, then reset before its response.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011;
        lsu_addr = 32'h0000_0800; lsu_wdata = 32'h7777_8888; mem_gnt = 1'b1;
        #1;
        chk("store_we", 64'(mem_we), 64'd1);
        chk("store_be", 64'(mem_be), 64'h3);
        chk("store_wdata", 64'(mem_wdata), 64'h7777_8888);
        chk("store_gnt", 64'(lsu_gnt), 64'd1);
        tick();
        lsu_req = 1'b0; mem_gnt = 1'b0; rst = 1'b1; if_req = 1'b1;
        #1;
        chk("midreset_outputs_zero", 64'(any_out()), 64'd0);
        tick();
        rst = 1'b0; if_req = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h9999_0000;
        #1;
        chk("post_reset_no_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
